store_write_buffer: RTL and testbench

//  Posted-write FIFO between the MIPS core data port (memwrite/dataadr/writedata)
//  and data memory. Core stores retire in one cycle; the buffer drains them to

---
 rtl/store_write_buffer.sv | 120 ++++++++++++
 tb/tb_store_write_buffer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the core data port and data memory.
// Stores retire in one cycle and drain under a req/ack handshake; loads to pending addresses stall.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic          memread,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    output logic          stall,
    output logic          mem_req,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] adr_q   [DEPTH];
    logic [DW-1:0] data_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic full;
    logic push;
    logic pop;
    logic hit;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign mem_req = ~empty;
    assign push    = memwrite & ~full;
    assign pop     = mem_req & mem_ack;

    // Memory sees the oldest entry straight from storage, so the address and
    // data cannot change while a request waits for its ack.
    assign mem_adr   = adr_q[rd_ptr];
    assign mem_wdata = data_q[rd_ptr];

    // A load must wait while any still-pending store targets the same address;
    // the valid bit of an entry drops at its ack edge, releasing the stall.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (adr_q[i] == dataadr)) begin
                hit = 1'b1;
            end
        end
    end

    // A store in the same cycle owns the port, so its full-stall wins over any load hazard.
    always_comb begin
        stall = 1'b0;
        if (memwrite) begin
            stall = full;
        end else if (memread) begin
            stall = hit;
        end
    end

    // Storage and valid bits; push and pop never address the same slot because
    // push needs ~full and pop needs ~empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (push) begin
                adr_q[wr_ptr]   <= dataadr;
                data_q[wr_ptr]  <= writedata;
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset) begin
            assert (count <= CW'(DEPTH))
                else $error("store_write_buffer: occupancy above DEPTH");
        end
    end
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer: reset, drain, fill/stall,
// steady push/pop across wrap, and load-after-store hazards.
module tb_store_write_buffer;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic        memread;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        empty;

    int nCompared;
    int nMismatched;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } wr_t;

    wr_t memLog[$];

    store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .memread(memread),
        .dataadr(dataadr),
        .writedata(writedata),
        .stall(stall),
        .mem_req(mem_req),
        .mem_adr(mem_adr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: records every write the buffer hands over on an ack edge.
    always @(posedge clk) begin
        if (reset && mem_req && mem_ack) begin
            memLog.push_back('{mem_adr, mem_wdata});
        end
    end

    // Drives core/memory inputs at a falling edge and settles before any check.
    task automatic applyStimulus(input logic mw, input logic mr, input logic [31:0] adr,
                                 input logic [31:0] data, input logic ack);
        @(negedge clk);
        memwrite  = mw;
        memread   = mr;
        dataadr   = adr;
        writedata = data;
        mem_ack   = ack;
        #1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        nCompared++;
        if (mem_req !== 1'b0 || empty !== 1'b1 || stall !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: req=%b empty=%b stall=%b, want 0 1 0", mem_req, empty, stall);
        end
        nCompared++;
        if (mem_adr !== 32'h0 || mem_wdata !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_bus: adr=%h wdata=%h, want 0 0", mem_adr, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_single_store();
        $display("[TB] test_single_store");
        memLog.delete();
        applyStimulus(1'b1, 1'b0, 32'h54, 32'h7, 1'b1);
        nCompared++;
        if (mem_req !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL single_no_writethrough: req=%b, want 0", mem_req);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        nCompared++;
        if (mem_req !== 1'b1 || mem_adr !== 32'h54 || mem_wdata !== 32'h7) begin
            nMismatched++;
            $display("[TB] FAIL single_present: req=%b adr=%h wdata=%h, want 1 54 7", mem_req, mem_adr, mem_wdata);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        nCompared++;
        if (empty !== 1'b1 || mem_req !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL single_empty: empty=%b req=%b, want 1 0", empty, mem_req);
        end
        nCompared++;
        if (memLog.size() !== 1 || memLog[0].adr !== 32'h54 || memLog[0].data !== 32'h7) begin
            nMismatched++;
            $display("[TB] FAIL single_memlog: writes=%0d, want 1 write 54<-7", memLog.size());
        end
    endtask

    task automatic test_fill_stall();
        int waited;
        $display("[TB] test_fill_stall");
        memLog.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'(i + 1), 1'b0);
            nCompared++;
            if (stall !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL fill_nostall_%0d: stall=%b, want 0", i, stall);
            end
        end
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h5, 1'b0);
        nCompared++;
        if (stall !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL fill_full_stall: stall=%b, want 1", stall);
        end
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h5, 1'b1);
        nCompared++;
        if (stall !== 1'b1 || mem_adr !== 32'h10) begin
            nMismatched++;
            $display("[TB] FAIL fill_pop_edge_stall: stall=%b adr=%h, want 1 10", stall, mem_adr);
        end
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h5, 1'b1);
        nCompared++;
        if (stall !== 1'b0 || mem_adr !== 32'h14) begin
            nMismatched++;
            $display("[TB] FAIL fill_retry_accept: stall=%b adr=%h, want 0 14", stall, mem_adr);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        waited = 0;
        while (empty !== 1'b1 && waited < 20) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            waited++;
        end
        nCompared++;
        if (empty !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL fill_drain_timeout: empty=%b, want 1", empty);
        end
        nCompared++;
        if (memLog.size() !== 5) begin
            nMismatched++;
            $display("[TB] FAIL fill_write_count: writes=%0d, want 5", memLog.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                nCompared++;
                if (memLog[i].adr !== 32'h10 + 32'(4 * i) || memLog[i].data !== 32'(i + 1)) begin
                    nMismatched++;
                    $display("[TB] FAIL fill_order_%0d: got %h<-%h, want %h<-%h", i,
                             memLog[i].adr, memLog[i].data, 32'h10 + 32'(4 * i), 32'(i + 1));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int stallSeen;
        $display("[TB] test_back_to_back");
        memLog.delete();
        stallSeen = 0;
        applyStimulus(1'b1, 1'b0, 32'h100, 32'hA000, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h104, 32'hA001, 1'b0);
        for (int i = 2; i < 18; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b1);
            if (stall !== 1'b0 || mem_req !== 1'b1) stallSeen++;
        end
        nCompared++;
        if (stallSeen !== 0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_no_stall: bad cycles=%0d, want 0", stallSeen);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        nCompared++;
        if (empty !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_count_two: empty=%b after 1 drain, want 0", empty);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        nCompared++;
        if (empty !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL b2b_drained: empty=%b after 2 drains, want 1", empty);
        end
        nCompared++;
        if (memLog.size() !== 18) begin
            nMismatched++;
            $display("[TB] FAIL b2b_write_count: writes=%0d, want 18", memLog.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                nCompared++;
                if (memLog[i].adr !== 32'h100 + 32'(4 * i) || memLog[i].data !== 32'hA000 + 32'(i)) begin
                    nMismatched++;
                    $display("[TB] FAIL b2b_order_%0d: got %h<-%h", i, memLog[i].adr, memLog[i].data);
                end
            end
        end
    endtask

    task automatic test_load_hazard();
        $display("[TB] test_load_hazard");
        memLog.delete();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        nCompared++;
        if (mem_req !== 1'b0 || empty !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL ack_idle_ignored: req=%b empty=%b, want 0 1", mem_req, empty);
        end
        applyStimulus(1'b1, 1'b0, 32'h2C, 32'h9, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h2C, 32'h0, 1'b0);
        nCompared++;
        if (stall !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL load_hit_stall: stall=%b, want 1", stall);
        end
        dataadr = 32'h30;
        #1;
        nCompared++;
        if (stall !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL load_miss_nostall: stall=%b, want 0", stall);
        end
        applyStimulus(1'b0, 1'b1, 32'h2C, 32'h0, 1'b1);
        nCompared++;
        if (stall !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL load_stall_on_ack_cycle: stall=%b, want 1", stall);
        end
        applyStimulus(1'b0, 1'b1, 32'h2C, 32'h0, 1'b0);
        nCompared++;
        if (stall !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL load_stall_release: stall=%b, want 0", stall);
        end
        applyStimulus(1'b1, 1'b0, 32'h2C, 32'h1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h2C, 32'h2, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h2C, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h2C, 32'h0, 1'b1);
        nCompared++;
        if (stall !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL load_multi_hold: stall=%b, want 1", stall);
        end
        applyStimulus(1'b0, 1'b1, 32'h2C, 32'h0, 1'b0);
        nCompared++;
        if (stall !== 1'b0 || empty !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL load_multi_release: stall=%b empty=%b, want 0 1", stall, empty);
        end
        nCompared++;
        if (memLog.size() !== 3 || memLog[0].data !== 32'h9 || memLog[1].data !== 32'h1 || memLog[2].data !== 32'h2) begin
            nMismatched++;
            $display("[TB] FAIL load_memlog: writes=%0d, want 3 (9,1,2)", memLog.size());
        end
    endtask

    task automatic test_reset_midstream();
        $display("[TB] test_reset_midstream");
        memLog.delete();
        applyStimulus(1'b1, 1'b0, 32'h60, 32'h11, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h64, 32'h12, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h68, 32'h13, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        nCompared++;
        if (mem_req !== 1'b0 || empty !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midreset_immediate: req=%b empty=%b, want 0 1", mem_req, empty);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        end
        nCompared++;
        if (memLog.size() !== 0 || mem_req !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_no_stale: writes=%0d req=%b, want 0 0", memLog.size(), mem_req);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset     = 1'b0;
        memwrite  = 1'b0;
        memread   = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
        mem_ack   = 1'b0;
        #12;
        test_reset();
        test_single_store();
        test_fill_stall();
        test_back_to_back();
        test_load_hazard();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
